// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word-level scan engine around a programmable Mealy
// bit-pattern detector. A start handshake captures a data word, a pattern
// and an overlap mode. The word is then fed to the detector MSB-first, one
// bit per clock. The block counts matches (saturating) and records the bit
// position of the first match. A one-cycle done pulse reports completion.
module seq_detect_ctrl #(
  parameter  int DATA_W = 16,
  parameter  int PAT_W  = 4,
  parameter  int CNT_W  = 5,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              busy,
  output logic              done,
  output logic              ser_bit,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              found,
  output logic [IDX_W-1:0]  first_pos
);

  // hist_valid counts up to PAT_W-1, the number of history bits needed
  // before a full window exists.
  localparam int                HV_W     = $clog2(PAT_W);
  localparam logic [HV_W-1:0]   HV_MAX   = HV_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [HV_W-1:0]    hv_q, hv_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   first_q, first_d;

  logic               ser_w;
  logic               match_w;
  logic [PAT_W-1:0]   window;

  // Detector datapath: the current serial bit and the Mealy match.
  always_comb begin
    ser_w   = 1'b0;
    if (state_q == S_SHIFT) begin
      ser_w = data_q[IDX_LAST - idx_q];
    end
    window  = {hist_q, ser_w};
    match_w = (state_q == S_SHIFT) && (hv_q >= HV_MAX) && (window == pat_q);
  end

  // Next-state logic for the scan sequencer and the result registers.
  always_comb begin
    // NOTE: every variable gets a default here, so no path through the case
    // can leave one unassigned and infer a latch.
    state_d = state_q;
    data_d  = data_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    hv_d    = hv_q;
    idx_d   = idx_q;
    count_d = count_q;
    found_d = found_q;
    first_d = first_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          pat_d   = pattern;
          ovl_d   = overlap;
          hist_d  = '0;
          hv_d    = '0;
          idx_d   = '0;
          count_d = '0;
          found_d = 1'b0;
          first_d = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hist_d = window[PAT_W-2:0];
        // Non-overlapping mode discards the history, so the next match
        // needs PAT_W fresh bits.
        if (match_w && !ovl_q) begin
          hv_d = '0;
        end else if (hv_q != HV_MAX) begin
          hv_d = hv_q + HV_W'(1);
        end
        if (match_w) begin
          if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
          end
          if (!found_q) begin
            found_d = 1'b1;
            first_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // values, independent of the statement order.
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      hv_q    <= '0;
      idx_q   <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      hv_q    <= hv_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      found_q <= found_d;
      first_q <= first_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ser_bit     = ser_w;
  assign match       = match_w;
  assign match_count = count_q;
  assign found       = found_q;
  assign first_pos   = first_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl. The driver issues scans and pushes the
// reference model's result. A negedge monitor compares the outputs per bit
// and at each done pulse. A second instance with a 3-bit counter runs in
// lockstep to exercise counter saturation.
module tb_seq_detect_ctrl;

  localparam int DW = 16;
  localparam int PW = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data_in;
  logic [PW-1:0] pattern;
  logic          overlap;

  logic          busy, done, ser_bit, match, found;
  logic [4:0]    match_count;
  logic [IW-1:0] first_pos;

  logic          s_busy, s_done, s_ser_bit, s_match, s_found;
  logic [2:0]    s_match_count;
  logic [IW-1:0] s_first_pos;

  seq_detect_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .pattern(pattern), .overlap(overlap), .busy(busy), .done(done),
    .ser_bit(ser_bit), .match(match), .match_count(match_count),
    .found(found), .first_pos(first_pos)
  );

  seq_detect_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .pattern(pattern), .overlap(overlap), .busy(s_busy), .done(s_done),
    .ser_bit(s_ser_bit), .match(s_match), .match_count(s_match_count),
    .found(s_found), .first_pos(s_first_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mask;   // bit p set = match completes at position p
    int            count;
    int            first;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slide a PW-bit window over the word, MSB first. In
  // non-overlapping mode a match consumes its bits, so the next window must
  // start after it.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic ovl);
    exp_t e;
    int   earliest;
    logic [DW-1:0] win;
    e.data   = d;
    e.mask   = '0;
    e.count  = 0;
    e.first  = 0;
    earliest = PW - 1;
    for (int pos = 0; pos < DW; pos++) begin
      if (pos >= earliest) begin
        win = (d >> (DW - 1 - pos)) & ((1 << PW) - 1);
        if (win == DW'(p)) begin
          e.mask[pos] = 1'b1;
          if (e.count == 0) e.first = pos;
          e.count++;
          if (!ovl) earliest = pos + PW;
        end
      end
    end
    return e;
  endfunction

  // Monitor: per-bit check of ser_bit/match during SHIFT, result check on done.
  exp_t mon_e;
  initial begin
    int pos;
    pos = 0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        pos = 0;
      end else if (!done) begin
        if (sb.size() == 0) begin
          check("busy_without_scan", 32'(busy), 32'd0);
        end else if (pos >= DW) begin
          check("shift_overrun", 32'(pos), 32'(DW - 1));
        end else begin
          check("ser_bit", 32'(ser_bit), 32'(sb[0].data[DW-1-pos]));
          check("match", 32'(match), 32'(sb[0].mask[pos]));
          check("sat_match", 32'(s_match), 32'(sb[0].mask[pos]));
          check("sat_ser_bit", 32'(s_ser_bit), 32'(sb[0].data[DW-1-pos]));
          pos++;
        end
      end else begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_latency", 32'(pos), 32'(DW));
          check("match_count", 32'(match_count), 32'(mon_e.count));
          check("found", 32'(found), 32'(mon_e.count != 0));
          check("first_pos", 32'(first_pos), 32'(mon_e.first));
          check("sat_count", 32'(s_match_count), 32'((mon_e.count > 7) ? 7 : mon_e.count));
          check("sat_found", 32'(s_found), 32'(mon_e.count != 0));
          check("sat_first_pos", 32'(s_first_pos), 32'(mon_e.first));
          check("sat_done", 32'(s_done), 32'd1);
          check("sat_busy", 32'(s_busy), 32'd1);
        end
      end
    end
  end

  // Waits for IDLE, presents start for one cycle and records the expectation.
  task automatic issue(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic ovl);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
    data_in = d;
    pattern = p;
    overlap = ovl;
    start   = 1'b1;
    sb.push_back(model(d, p, ovl));
    @(negedge clk);
    start = 1'b0;
    check("start_accepted", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ser_bit"}, 32'(ser_bit), 32'd0);
    check({tag, "_match"}, 32'(match), 32'd0);
    check({tag, "_count"}, 32'(match_count), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_first_pos"}, 32'(first_pos), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int d0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    overlap = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Directed cases, back-to-back: each start lands the cycle after done.
    issue(16'h7777, 4'b0111, 1'b1);
    issue(16'hFFFF, 4'b1111, 1'b1);
    issue(16'hFFFF, 4'b1111, 1'b0);
    issue(16'h0000, 4'b0111, 1'b1);
    issue(16'hAAAA, 4'b1010, 1'b0);
    issue(16'hAAAA, 4'b1010, 1'b1);

    // A start pulse in the middle of a scan must be ignored.
    issue(16'h7777, 4'b0111, 1'b1);
    repeat (5) @(negedge clk);
    data_in = 16'hFFFF;
    pattern = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset at idx 8 aborts the scan: outputs clear and done never fires.
    issue(16'h7777, 4'b0111, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    void'(sb.pop_front());
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(d0));
    issue(16'h7777, 4'b0111, 1'b1);

    // Random scans.
    for (int i = 0; i < 40; i++) begin
      issue(DW'($urandom), PW'($urandom), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
